// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
// rns_pkg: moduli, inverses, mixed-radix weights and FSM states for the
// {3,5,7} residue number system reverse converter.
// Revision: 1.0
// ============================================================================
package rns_pkg;

  localparam int M3      = 3;
  localparam int M5      = 5;
  localparam int M7      = 7;
  localparam int M_RANGE = 105;

  localparam int INV3_MOD5 = 2;
  localparam int INV3_MOD7 = 5;
  localparam int INV5_MOD7 = 3;

  localparam int W2 = 3;
  localparam int W3 = 15;

  // Largest value kept positive when mapping onto the symmetric range.
  localparam int HALF_RANGE = 52;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D2   = 3'd1,
    D3   = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rns_mrc_digit.sv
`default_nettype none
// ============================================================================
// rns_mrc_digit: combinational mixed-radix digit step, d = ((a-b) mod MOD * INV) mod MOD.
// Revision: 1.0
// ============================================================================
module rns_mrc_digit #(
  parameter int MOD = 5,
  parameter int INV = 2
) (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] d
);

  localparam logic [3:0] c_mod4 = 4'(MOD);

  logic [3:0] w_sum;
  logic [3:0] w_diff;
  logic [3:0] w_acc;

  always_comb begin
    w_sum  = {1'b0, a} + c_mod4 - {1'b0, b};
    w_diff = (w_sum >= c_mod4) ? (w_sum - c_mod4) : w_sum;
    // Multiply by the constant inverse as repeated modular addition.
    w_acc  = w_diff;
    for (int i = 1; i < INV; i++) begin
      w_acc = w_acc + w_diff;
      if (w_acc >= c_mod4) begin
        w_acc = w_acc - c_mod4;
      end
    end
    d = (w_acc >= c_mod4) ? 3'(w_acc - c_mod4) : 3'(w_acc);
  end

endmodule
`default_nettype wire

// File: rtl/rns_reverse_converter.sv
`default_nettype none
// ============================================================================
// rns_reverse_converter: residue triple {3,5,7} to binary via iterative MRC.
// Optional RNS_REVCONV_SIGNED_EN: result mapped onto the symmetric range [-52,52].
// Revision: 1.0
// ============================================================================
module rns_reverse_converter
  import rns_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r3,
  input  logic [WIDTH-1:0] in_r5,
  input  logic [WIDTH-1:0] in_r7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_err
);

  state_t           r_state;
  state_t           w_next_state;

  logic [2:0]       r_a1;
  logic [2:0]       r_r5;
  logic [2:0]       r_r7;
  logic [2:0]       r_a2;
  logic [2:0]       r_a3;
  logic             r_err;
  logic [WIDTH-1:0] r_out_x;
  logic             r_out_err;

  logic             w_range_err;
  logic [2:0]       w_a2;
  logic [2:0]       w_t;
  logic [2:0]       w_a3;
  logic [6:0]       w_x7;
  logic [WIDTH-1:0] w_x_out;

  // Full-width compare so any set upper bit flags the triple as invalid.
  assign w_range_err = (in_r3 >= WIDTH'(M3)) ||
                       (in_r5 >= WIDTH'(M5)) ||
                       (in_r7 >= WIDTH'(M7));

  rns_mrc_digit #(.MOD(M5), .INV(INV3_MOD5)) u_digit_a2 (
    .a (r_r5),
    .b (r_a1),
    .d (w_a2)
  );

  rns_mrc_digit #(.MOD(M7), .INV(INV3_MOD7)) u_digit_t (
    .a (r_r7),
    .b (r_a1),
    .d (w_t)
  );

  rns_mrc_digit #(.MOD(M7), .INV(INV5_MOD7)) u_digit_a3 (
    .a (w_t),
    .b (r_a2),
    .d (w_a3)
  );

  assign w_x7 = 7'(r_a1) + 7'(r_a2) * 7'(W2) + 7'(r_a3) * 7'(W3);

`ifdef RNS_REVCONV_SIGNED_EN
  assign w_x_out = (w_x7 > 7'(HALF_RANGE)) ? (WIDTH'(w_x7) - WIDTH'(M_RANGE))
                                           : WIDTH'(w_x7);
`else
  assign w_x_out = WIDTH'(w_x7);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = D2;
        end
      end
      D2:  w_next_state = D3;
      D3:  w_next_state = ACC;
      ACC: w_next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a1      <= '0;
      r_r5      <= '0;
      r_r7      <= '0;
      r_a2      <= '0;
      r_a3      <= '0;
      r_err     <= 1'b0;
      r_out_x   <= '0;
      r_out_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a1  <= in_r3[2:0];
            r_r5  <= in_r5[2:0];
            r_r7  <= in_r7[2:0];
            r_err <= w_range_err;
          end
        end
        D2:  r_a2 <= w_a2;
        D3:  r_a3 <= w_a3;
        ACC: begin
          r_out_x   <= r_err ? '0 : w_x_out;
          r_out_err <= r_err;
        end
        default: ;
      endcase
    end
  end

  assign out_x   = r_out_x;
  assign out_err = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_rns_reverse_converter.sv
`default_nettype none
// tb_rns_reverse_converter: scoreboard bench for the {3,5,7} reverse converter.
// Build with RNS_REVCONV_SIGNED_EN to check the symmetric-range variant.
module tb_rns_reverse_converter;

  localparam int WIDTH = 32;
  localparam int LAT   = 4;
  localparam int BOUND = 20;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_r3 = '0;
  logic [WIDTH-1:0] in_r5 = '0;
  logic [WIDTH-1:0] in_r7 = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_x;
  logic             out_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  rns_reverse_converter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r3     (in_r3),
    .in_r5     (in_r5),
    .in_r7     (in_r7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_err   (out_err)
  );

  // Expected out_x for an integer 0..104 in the active build.
  function automatic logic [WIDTH-1:0] to_out(input int x);
    logic [WIDTH-1:0] v;
    v = WIDTH'(x);
`ifdef RNS_REVCONV_SIGNED_EN
    if (x > 52) v = WIDTH'(x) - WIDTH'(105);
`endif
    return v;
  endfunction

  // Drive one triple, record its expectation, wait for out_valid.
  task automatic send(input logic [WIDTH-1:0] r3, input logic [WIDTH-1:0] r5,
                      input logic [WIDTH-1:0] r7, input exp_t e,
                      output int lat, output logic ready_low);
    int n;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    in_r3 = r3; in_r5 = r5; in_r7 = r7; in_valid = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < BOUND) begin
      if (in_ready) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_x !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_x=%h out_err=%b, need 1 0 0 0",
               in_ready, out_valid, out_x, out_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] tr3[5] = '{0, 2, 1, 2, 1};
    logic [WIDTH-1:0] tr5[5] = '{0, 4, 2, 3, 1};
    logic [WIDTH-1:0] tr7[5] = '{0, 6, 3, 4, 1};
`ifdef RNS_REVCONV_SIGNED_EN
    logic [WIDTH-1:0] tx[5] = '{32'd0, 32'hFFFF_FFFF, 32'd52, 32'hFFFF_FFCC, 32'd1};
`else
    logic [WIDTH-1:0] tx[5] = '{32'd0, 32'd104, 32'd52, 32'd53, 32'd1};
`endif
    int   lat;
    logic rl;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      send(tr3[i], tr5[i], tr7[i], '{x: tx[i], err: 1'b0}, lat, rl);
      e = sb_q.pop_front();
      checks++;
      if (lat !== LAT || rl !== 1'b1) begin
        errors++;
        $display("FAIL directed_latency[%0d]: lat=%0d in_ready_low=%b, need %0d 1", i, lat, rl, LAT);
      end
      checks++;
      if (out_x !== e.x || out_err !== e.err) begin
        errors++;
        $display("FAIL directed_value[%0d]: out_x=%h out_err=%b, need %h %b", i, out_x, out_err, e.x, e.err);
      end
      release_out();
    end
  endtask

  task automatic test_range_error();
    logic [WIDTH-1:0] tr3[3] = '{3, 0, 0};
    logic [WIDTH-1:0] tr5[3] = '{0, 0, 32'h0000_0100};
    logic [WIDTH-1:0] tr7[3] = '{0, 7, 0};
    int   lat;
    logic rl;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(tr3[i], tr5[i], tr7[i], '{x: '0, err: 1'b1}, lat, rl);
      e = sb_q.pop_front();
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL err_latency[%0d]: lat=%0d, need %0d", i, lat, LAT);
      end
      checks++;
      if (out_x !== e.x || out_err !== e.err) begin
        errors++;
        $display("FAIL err_value[%0d]: out_x=%h out_err=%b, need %h %b", i, out_x, out_err, e.x, e.err);
      end
      release_out();
    end
  endtask

  task automatic test_early_ready();
    int   lat;
    logic rl;
    exp_t e;
    out_ready = 1'b1;
    send(1, 2, 3, '{x: to_out(52), err: 1'b0}, lat, rl);
    e = sb_q.pop_front();
    checks++;
    if (lat !== LAT || out_x !== e.x || out_err !== e.err) begin
      errors++;
      $display("FAIL early_ready: lat=%0d out_x=%h out_err=%b, need %0d %h %b",
               lat, out_x, out_err, LAT, e.x, e.err);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_ready_once: out_valid=%b after consume, need 0", out_valid);
    end
  endtask

  task automatic test_sweep();
    int               lat;
    int               hold;
    int               n_out;
    logic             rl;
    logic             stable;
    logic [WIDTH-1:0] held_x;
    exp_t             e;
    n_out = 0;
    for (int x = 0; x < 105; x++) begin
      send(WIDTH'(x % 3), WIDTH'(x % 5), WIDTH'(x % 7), '{x: to_out(x), err: 1'b0}, lat, rl);
      stable = 1'b1;
      held_x = out_x;
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_x !== held_x) stable = 1'b0;
      end
      e = sb_q.pop_front();
      n_out++;
      checks++;
      if (lat !== LAT || rl !== 1'b1 || stable !== 1'b1) begin
        errors++;
        $display("FAIL sweep_handshake[%0d]: lat=%0d in_ready_low=%b stable=%b, need %0d 1 1",
                 x, lat, rl, stable, LAT);
      end
      checks++;
      if (out_x !== e.x || out_err !== e.err) begin
        errors++;
        $display("FAIL sweep_value[%0d]: out_x=%h out_err=%b, need %h %b", x, out_x, out_err, e.x, e.err);
      end
      release_out();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_dup[%0d]: out_valid=%b after consume, need 0", x, out_valid);
      end
    end
    checks++;
    if (n_out !== 105 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL sweep_count: results=%0d pending=%0d, need 105 0", n_out, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    int   lat;
    logic rl;
    logic seen;
    exp_t e;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    in_r3 = 2; in_r5 = 4; in_r7 = 6; in_valid = 1'b1;
    sb_q.push_back('{x: to_out(104), err: 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_x !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b out_x=%h out_err=%b, need 1 0 0 0",
               in_ready, out_valid, out_x, out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stale: out_valid seen=%b after release, need 0", seen);
    end
    send(1, 1, 1, '{x: to_out(1), err: 1'b0}, lat, rl);
    e = sb_q.pop_front();
    checks++;
    if (lat !== LAT || out_x !== e.x || out_err !== e.err) begin
      errors++;
      $display("FAIL reset_mid_next: lat=%0d out_x=%h out_err=%b, need %0d %h %b",
               lat, out_x, out_err, LAT, e.x, e.err);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_range_error();
    test_early_ready();
    test_sweep();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, need completion before 1000000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rns_reverse_converter.md
Name: rns_reverse_converter

Overview:
- Residue-to-binary (reverse) converter for the RNS datapath, moduli set {3,5,7}, dynamic range M=105.
- Complements the forward path, which builds residues from 2^i mod m weight tables.
- Takes a residue triple over a valid/ready handshake and reconstructs the integer X in [0,104] by iterative mixed-radix conversion (MRC).
- Returns X over a second valid/ready handshake; sits at the output of the RNS arithmetic core.

Parameters:
- WIDTH, 32, width of residue input ports and of the result port; must be >= 8.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  residue triple present
- in_ready  output  1  converter can accept a triple
- in_r3  input  WIDTH  residue mod 3
- in_r5  input  WIDTH  residue mod 5
- in_r7  input  WIDTH  residue mod 7
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_x  output  WIDTH  reconstructed integer, zero-extended
- out_err  output  1  input residue was out of range; out_x forced to 0

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_x=0, out_err=0, FSM=IDLE, all digit registers 0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch the residues, set a1=r3, go to D2.
  - D2: a2 = ((r5 - a1) mod 5 * 2) mod 5, where 2 = 3^-1 mod 5. Go to D3.
  - D3: t = ((r7 - a1) mod 7 * 5) mod 7, where 5 = 3^-1 mod 7; a3 = ((t - a2) mod 7 * 3) mod 7, where 3 = 5^-1 mod 7. Go to ACC.
  - ACC: X = a1 + 3*a2 + 15*a3, computed in 7 bits (max 104). Register out_x, go to DONE.
  - DONE: out_valid=1; out_x and out_err stable. On out_ready, go to IDLE.
- Latency: handshake accepted in cycle 0; out_valid rises in cycle 4.
- Throughput: one conversion per 5 cycles minimum. in_ready=0 in every state except IDLE.
- Modular subtraction is implemented as add-modulus-then-conditional-subtract; no `%` operator on WIDTH-bit values.
- Range check at accept: if r3>=3, r5>=5 or r7>=7, set an err flag. The FSM still walks all states (fixed latency). In DONE: out_err=1, out_x=0.
- Upper bits of the inputs above the range check are treated as part of the value, so any nonzero upper bit triggers err.
- out_ready held high before DONE has no effect.
- out_valid must not drop without out_ready.
- Reset asserted mid-conversion: conversion is discarded immediately, all outputs return to reset values, no stale result is emitted.

Optional Feature:
- Macro: RNS_REVCONV_SIGNED_EN.
- Defined: output uses the symmetric range. If X>52, out_x = X-105 sign-extended to WIDTH (two's complement). Range is [-52,52].
- Undefined: unsigned X in [0,104], zero-extended.
- Latency is identical in both builds; the correction happens in the ACC cycle.

Decomposition:
- Package rns_pkg holds:
  - moduli constants M3=3, M5=5, M7=7, M_RANGE=105;
  - multiplicative inverses INV3_MOD5=2, INV3_MOD7=5, INV5_MOD7=3;
  - mixed-radix weights W2=3, W3=15;
  - FSM state enum (IDLE, D2, D3, ACC, DONE).
- One sub-module, rns_mrc_digit: combinational ((a-b) mod m * inv) mod m over 3-bit operands, parameterised by modulus and inverse. Instantiated three times (D2 and both steps of D3).

Test Plan:
- Reset then triple (0,0,0) -> out_valid in cycle 4, out_x=0, out_err=0.
- Triple (2,4,6) -> out_x=104. With RNS_REVCONV_SIGNED_EN: out_x=0xFFFFFFFF (-1).
- Triple (1,2,3) -> out_x=52 in both builds. Triple (2,3,4) -> 53 unsigned, 0xFFFFFFCC (-52) signed.
- Exhaustive sweep X=0..104 with residues from a golden model, random out_ready backpressure -> every out_x matches, in_ready low during each conversion, no lost or duplicated result.
- Triple (3,0,0) and triple (0,0,7) -> out_err=1, out_x=0, latency still 4 cycles.
- rst_n pulsed low during D3 with triple (2,4,6) in flight -> outputs return to reset values asynchronously, no out_valid after release; next triple (1,1,1) -> out_x=1.
